// File: rtl/inst_decode_ctrl.sv
// Decode stage behind instruction fetch: buffers fetched words, resolves J/JAL/JR, hands the rest to execute.
// Optional INST_DECODE_STATS_EN adds retired/jump/flushed event counters.
module inst_decode_ctrl #(
   parameter int p_word_bits      = 32,
   parameter int p_addr_bits      = 32,
   parameter int p_buf_depth      = 4,
   parameter int p_buf_depth_log2 = 2,
   parameter int p_flush_cycles   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [p_word_bits-1:0] i_inst,
   input  logic                   i_inst_valid,
   output logic                   o_inst_complete,
   output logic [p_addr_bits-1:0] o_j_addr,
   output logic                   o_j_valid,
   output logic [p_addr_bits-1:0] o_jal_addr,
   output logic                   o_jal_valid,
   output logic [p_addr_bits-1:0] o_jr_addr,
   output logic                   o_jr_valid,
   output logic [4:0]             o_rs_idx,
   input  logic [p_word_bits-1:0] i_rs_data,
   output logic [p_addr_bits-1:0] o_link_addr,
   output logic                   o_link_valid,
   output logic [p_word_bits-1:0] o_dec_inst,
   output logic [p_addr_bits-1:0] o_dec_pc,
   output logic                   o_dec_valid,
   input  logic                   i_dec_ready,
   output logic                   o_overflow
`ifdef INST_DECODE_STATS_EN
   ,
   output logic [31:0]            o_stat_retired,
   output logic [31:0]            o_stat_jumps,
   output logic [31:0]            o_stat_flushed
`endif
);

   localparam int cnt_w   = p_buf_depth_log2 + 1;
   localparam int flush_w = $clog2(p_flush_cycles + 2);
   localparam logic [cnt_w-1:0]   cnt_full   = cnt_w'(p_buf_depth);
   localparam logic [flush_w-1:0] flush_load = flush_w'(p_flush_cycles);

   typedef enum logic [1:0] {IDLE, DISPATCH, FLUSH} state_t;

   state_t                        state;
   logic [p_word_bits-1:0]        mem [p_buf_depth];
   logic [p_buf_depth_log2-1:0]   wr_ptr, rd_ptr;
   logic [cnt_w-1:0]              count;
   logic [p_addr_bits-1:0]        pc;
   logic [flush_w-1:0]            flush_cnt;

   logic [p_word_bits-1:0]        head;
   logic                          head_valid, is_j, is_jal, is_jr, is_jump;
   logic                          push, push_ok, pop, full;
   logic [p_addr_bits-1:0]        abs_target, pc_next4;

   always_comb begin
      head       = mem[rd_ptr];
      head_valid = (state == DISPATCH);
      is_j       = head_valid && (head[31:26] == 6'h02);
      is_jal     = head_valid && (head[31:26] == 6'h03);
      is_jr      = head_valid && (head[31:26] == 6'h00) && (head[5:0] == 6'h08);
      is_jump    = is_j || is_jal || is_jr;
      abs_target = {pc[p_addr_bits-1:28], head[25:0], 2'b00};
      pc_next4   = pc + p_addr_bits'(4);
      full       = (count == cnt_full);
      pop        = head_valid && !is_jump && i_dec_ready;
      // the jump cycle clears the buffer, so a word arriving alongside it is dropped too
      push       = i_inst_valid && (state != FLUSH) && !is_jump;
      push_ok    = push && (!full || pop);
   end

   assign o_dec_valid     = head_valid && !is_jump;
   assign o_dec_inst      = head;
   assign o_dec_pc        = pc;
   assign o_rs_idx        = head[25:21];
   assign o_j_valid       = is_j;
   assign o_j_addr        = abs_target;
   assign o_jal_valid     = is_jal;
   assign o_jal_addr      = abs_target;
   assign o_jr_valid      = is_jr;
   assign o_jr_addr       = p_addr_bits'(i_rs_data);
   assign o_link_valid    = is_jal;
   assign o_link_addr     = pc_next4;
   assign o_inst_complete = is_jump || pop;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= i_inst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pc         <= '0;
         flush_cnt  <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + p_buf_depth_log2'(1);
         if (pop)     rd_ptr <= rd_ptr + p_buf_depth_log2'(1);
         if (push && full && !pop) o_overflow <= 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + cnt_w'(1);
            2'b01:   count <= count - cnt_w'(1);
            default: count <= count;
         endcase

         case (state)
            IDLE: if (push_ok) state <= DISPATCH;
            DISPATCH: begin
               if (is_jump) begin
                  pc        <= is_jr ? p_addr_bits'(i_rs_data) : abs_target;
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  count     <= '0;
                  flush_cnt <= flush_load;
                  state     <= (p_flush_cycles == 0) ? IDLE : FLUSH;
               end else if (pop) begin
                  pc <= pc_next4;
                  if (count == cnt_w'(1) && !push_ok) state <= IDLE;
               end
            end
            FLUSH: begin
               if (flush_cnt <= flush_w'(1)) begin
                  flush_cnt <= '0;
                  state     <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt - flush_w'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INST_DECODE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         o_stat_retired <= '0;
         o_stat_jumps   <= '0;
         o_stat_flushed <= '0;
      end else begin
         if (o_inst_complete)                     o_stat_retired <= o_stat_retired + 32'd1;
         if (is_jump)                             o_stat_jumps   <= o_stat_jumps + 32'd1;
         if (state == FLUSH && i_inst_valid)      o_stat_flushed <= o_stat_flushed + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_decode_ctrl.sv
// Bench for inst_decode_ctrl: directed vector table, reset sequence, then random traffic vs a queue model.
// Stats outputs are checked only when INST_DECODE_STATS_EN is defined.
module tb_inst_decode_ctrl;
   localparam int DEPTH   = 4;
   localparam int FLUSH_N = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_inst = '0;
   logic        i_inst_valid = 1'b0;
   logic [31:0] i_rs_data = '0;
   logic        i_dec_ready = 1'b0;
   logic        o_inst_complete, o_j_valid, o_jal_valid, o_jr_valid, o_link_valid;
   logic        o_dec_valid, o_overflow;
   logic [31:0] o_j_addr, o_jal_addr, o_jr_addr, o_link_addr, o_dec_inst, o_dec_pc;
   logic [4:0]  o_rs_idx;
`ifdef INST_DECODE_STATS_EN
   logic [31:0] o_stat_retired, o_stat_jumps, o_stat_flushed;
`endif

   always #5 clk = ~clk;

   inst_decode_ctrl #(
      .p_word_bits(32), .p_addr_bits(32), .p_buf_depth(DEPTH),
      .p_buf_depth_log2(2), .p_flush_cycles(FLUSH_N)
   ) dut (
      .clk(clk), .rst(rst), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
      .o_inst_complete(o_inst_complete), .o_j_addr(o_j_addr), .o_j_valid(o_j_valid),
      .o_jal_addr(o_jal_addr), .o_jal_valid(o_jal_valid), .o_jr_addr(o_jr_addr),
      .o_jr_valid(o_jr_valid), .o_rs_idx(o_rs_idx), .i_rs_data(i_rs_data),
      .o_link_addr(o_link_addr), .o_link_valid(o_link_valid), .o_dec_inst(o_dec_inst),
      .o_dec_pc(o_dec_pc), .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready),
      .o_overflow(o_overflow)
`ifdef INST_DECODE_STATS_EN
      , .o_stat_retired(o_stat_retired), .o_stat_jumps(o_stat_jumps),
      .o_stat_flushed(o_stat_flushed)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model: pending words, pc, cycles of discard left, sticky overflow
   logic [31:0] q[$];
   logic [31:0] m_pc = '0;
   int          flush_left = 0;
   bit          m_ovf = 1'b0;
   logic [31:0] m_ret = '0, m_jmp = '0, m_fl = '0;

   typedef struct {
      logic        v;
      logic [31:0] w;
      logic        r;
      logic [31:0] rs;
      logic [6:0]  f;   // {dec_valid, j, jal, jr, link, complete, overflow}
      logic [31:0] a;   // dec_pc or jump target
      logic [31:0] lk;
      logic [31:0] di;
   } vec_t;
   vec_t tbl[$];

   localparam logic [6:0] F0 = 7'b0000000, NJ = 7'b1000010, DV = 7'b1000000;
   localparam logic [6:0] JF = 7'b0100010, JALF = 7'b0010110, JRF = 7'b0001010;
   localparam logic [31:0] J_W = 32'h0800_0040, JAL_W = 32'h0C00_0010, JR_W = 32'h03E0_0008;

   function automatic int kind(input logic [31:0] w);
      if (w[31:26] == 6'h02) return 1;
      if (w[31:26] == 6'h03) return 2;
      if (w[31:26] == 6'h00 && w[5:0] == 6'h08) return 3;
      return 0;
   endfunction

   function automatic logic [31:0] abs_tgt(input logic [31:0] pc, input logic [31:0] w);
      return {pc[31:28], w[25:0], 2'b00};
   endfunction

   function automatic logic [6:0] cur_flags();
      return {o_dec_valid, o_j_valid, o_jal_valid, o_jr_valid, o_link_valid,
              o_inst_complete, o_overflow};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [31:0] w, input logic r, input logic [31:0] rs,
                      input logic [6:0] f, input logic [31:0] a, input logic [31:0] lk,
                      input logic [31:0] di);
      vec_t t;
      t.v = v; t.w = w; t.r = r; t.rs = rs; t.f = f; t.a = a; t.lk = lk; t.di = di;
      tbl.push_back(t);
   endtask

   task automatic model_check();
      bit          head;
      int          k;
      logic [31:0] hw;
      logic [6:0]  ef;
      head = (q.size() > 0) && (flush_left == 0);
      hw   = head ? q[0] : '0;
      k    = head ? kind(hw) : -1;
      ef   = {k == 0, k == 1, k == 2, k == 3, k == 2, (k > 0) || (k == 0 && i_dec_ready), m_ovf};
      chk("model_flags", 32'(cur_flags()), 32'(ef));
      if (k == 0) begin
         chk("model_dec_pc", o_dec_pc, m_pc);
         chk("model_dec_inst", o_dec_inst, hw);
      end
      if (k == 1) chk("model_j_addr", o_j_addr, abs_tgt(m_pc, hw));
      if (k == 2) begin
         chk("model_jal_addr", o_jal_addr, abs_tgt(m_pc, hw));
         chk("model_link_addr", o_link_addr, m_pc + 32'd4);
      end
      if (k == 3) chk("model_jr_addr", o_jr_addr, i_rs_data);
      if (head) chk("model_rs_idx", 32'(o_rs_idx), 32'(hw[25:21]));
`ifdef INST_DECODE_STATS_EN
      chk("stat_retired", o_stat_retired, m_ret);
      chk("stat_jumps", o_stat_jumps, m_jmp);
      chk("stat_flushed", o_stat_flushed, m_fl);
`endif
   endtask

   task automatic model_update();
      bit head, jumped;
      int k;
      head   = (q.size() > 0) && (flush_left == 0);
      jumped = 1'b0;
      if (rst) begin
         q.delete(); m_pc = '0; flush_left = 0; m_ovf = 1'b0;
         m_ret = '0; m_jmp = '0; m_fl = '0;
      end else if (flush_left > 0) begin
         flush_left--;
         if (i_inst_valid) m_fl++;
      end else begin
         if (head) begin
            k = kind(q[0]);
            if (k != 0) begin
               m_pc = (k == 3) ? i_rs_data : abs_tgt(m_pc, q[0]);
               q.delete();
               flush_left = FLUSH_N;
               jumped = 1'b1;
               m_jmp++; m_ret++;
            end else if (i_dec_ready) begin
               void'(q.pop_front());
               m_pc = m_pc + 32'd4;
               m_ret++;
            end
         end
         if (i_inst_valid && !jumped) begin
            if (q.size() < DEPTH) q.push_back(i_inst);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic apply(input logic r, input logic v, input logic [31:0] w, input logic rd,
                        input logic [31:0] rs);
      rst = r; i_inst_valid = v; i_inst = w; i_dec_ready = rd; i_rs_data = rs;
      @(negedge clk);
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   vec_t        t;
   logic [31:0] w;
   int          sel;

   initial begin
      // directed table: sequential words, JAL/JR/J with flush windows, then overflow with ready held low
      add(1, 32'h2001_0005, 1, 0, F0, 0, 0, 0);
      add(1, 32'h2002_0006, 1, 0, NJ, 32'h0, 0, 32'h2001_0005);
      add(1, 32'h0022_1820, 1, 0, NJ, 32'h4, 0, 32'h2002_0006);
      add(0, 0, 1, 0, NJ, 32'h8, 0, 32'h0022_1820);
      add(0, 0, 1, 0, F0, 0, 0, 0);
      add(1, JAL_W, 1, 0, F0, 0, 0, 0);
      add(0, 0, 1, 0, JALF, 32'h40, 32'h10, 0);
      for (int i = 0; i < 8; i++) add(1, 32'h1111_0000 + 32'(i), 1, 0, F0, 0, 0, 0);
      add(1, JR_W, 1, 0, F0, 0, 0, 0);
      add(0, 0, 1, 32'h1000_0000, JRF, 32'h1000_0000, 0, 0);
      for (int i = 0; i < 8; i++) add(1, 32'h1111_1000 + 32'(i), 1, 0, F0, 0, 0, 0);
      add(1, J_W, 1, 0, F0, 0, 0, 0);
      add(0, 0, 1, 0, JF, 32'h1000_0100, 0, 0);
      for (int i = 0; i < 8; i++) add(1, 32'h2222_0000 + 32'(i), 1, 0, F0, 0, 0, 0);
      add(1, 32'h2001_0005, 1, 0, F0, 0, 0, 0);
      add(0, 0, 1, 0, NJ, 32'h1000_0100, 0, 32'h2001_0005);
      add(1, JR_W, 1, 0, F0, 0, 0, 0);
      add(0, 0, 1, 32'h20, JRF, 32'h20, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 0, 1, 0, F0, 0, 0, 0);
      add(1, JAL_W, 1, 0, F0, 0, 0, 0);
      add(0, 0, 1, 0, JALF, 32'h40, 32'h24, 0);
      for (int i = 0; i < 8; i++) add(0, 0, 1, 0, F0, 0, 0, 0);
      add(1, JR_W, 1, 0, F0, 0, 0, 0);
      add(0, 0, 1, 32'h1234, JRF, 32'h1234, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 0, 1, 0, F0, 0, 0, 0);
      add(1, 32'h8C00_1001, 0, 0, F0, 0, 0, 0);
      for (int i = 2; i <= 5; i++) add(1, 32'h8C00_1000 + 32'(i), 0, 0, DV, 32'h1234, 0, 32'h8C00_1001);
      add(0, 0, 0, 0, DV | 7'b1, 32'h1234, 0, 32'h8C00_1001);
      for (int i = 0; i < 4; i++)
         add(0, 0, 1, 0, NJ | 7'b1, 32'h1234 + 32'(4 * i), 0, 32'h8C00_1001 + 32'(i));
      add(0, 0, 1, 0, 7'b1, 0, 0, 0);

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      apply(0, 0, 0, 1, 0);
      chk("reset_flags", 32'(cur_flags()), 32'h0);
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         apply(0, t.v, t.w, t.r, t.rs);
         chk("tbl_flags", 32'(cur_flags()), 32'(t.f));
         if (t.f[6]) begin
            chk("tbl_dec_pc", o_dec_pc, t.a);
            chk("tbl_dec_inst", o_dec_inst, t.di);
         end
         if (t.f[5]) chk("tbl_j_addr", o_j_addr, t.a);
         if (t.f[4]) begin
            chk("tbl_jal_addr", o_jal_addr, t.a);
            chk("tbl_link_addr", o_link_addr, t.lk);
         end
         if (t.f[3]) begin
            chk("tbl_jr_addr", o_jr_addr, t.a);
            chk("tbl_jr_rs_idx", 32'(o_rs_idx), 32'd31);
         end
         tick();
      end

      // reset while two entries are buffered and a word is on offer to execute
      apply(0, 1, 32'h8C00_2001, 0, 0); tick();
      apply(0, 1, 32'h8C00_2002, 0, 0); tick();
      apply(1, 0, 0, 0, 0);
      chk("rst_pre_dec_valid", 32'(o_dec_valid), 32'd1);
      chk("rst_pre_overflow", 32'(o_overflow), 32'd1);
      tick();
      apply(0, 0, 0, 1, 0);
      chk("rst_post_dec_valid", 32'(o_dec_valid), 32'd0);
      chk("rst_post_overflow", 32'(o_overflow), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, 0, 1, 0);
         chk("rst_no_dispatch", 32'(o_dec_valid), 32'd0);
         tick();
      end
      apply(0, 1, 32'h8C00_2003, 1, 0); tick();
      apply(0, 0, 0, 1, 0);
      chk("rst_pc_zero", o_dec_pc, 32'd0);
      tick();

      for (int c = 0; c < 3000; c++) begin
         sel = $urandom_range(0, 99);
         w   = $urandom;
         if (sel < 4) w[31:26] = 6'h02;
         else if (sel < 8) w[31:26] = 6'h03;
         else if (sel < 12) begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
         else if (w[31:26] == 6'h02 || w[31:26] == 6'h03) w[31:26] = 6'h23;
         apply($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 7, w,
               $urandom_range(0, 9) < 6, $urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/inst_decode_ctrl.md
Name: inst_decode_ctrl

Overview:
Downstream stage of the instruction fetch controller. It consumes the fetched instruction word stream (valid-only, no backpressure) and buffers it. It decodes control-flow instructions (J, JAL, JR) and returns jump requests plus a completion pulse to fetch. All other instructions go to the execute stage over a valid/ready handshake, tagged with their PC.

Parameters:
p_word_bits, 32, instruction/data word width
p_addr_bits, 32, memory address width
p_buf_depth, 4, input buffer entries (power of two)
p_buf_depth_log2, 2, log2(p_buf_depth)
p_flush_cycles, 8, cycles incoming words are discarded after a jump

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_inst  in  p_word_bits  fetched instruction word
i_inst_valid  in  1  i_inst valid; always accepted, no ready
o_inst_complete  out  1  one-cycle pulse per instruction retired by this stage
o_j_addr  out  p_addr_bits  J target
o_j_valid  out  1  J request pulse
o_jal_addr  out  p_addr_bits  JAL target
o_jal_valid  out  1  JAL request pulse
o_jr_addr  out  p_addr_bits  JR target
o_jr_valid  out  1  JR request pulse
o_rs_idx  out  5  register-file read index, = head inst[25:21]
i_rs_data  in  p_word_bits  combinational register-file read data
o_link_addr  out  p_addr_bits  JAL link value (pc+4)
o_link_valid  out  1  write o_link_addr to r31; equals o_jal_valid
o_dec_inst  out  p_word_bits  non-jump instruction to execute
o_dec_pc  out  p_addr_bits  PC of o_dec_inst
o_dec_valid  out  1  o_dec_inst valid
i_dec_ready  in  1  execute accepts
o_overflow  out  1  sticky: word arrived while buffer full

Behaviour:
- Reset: buffer empty, pc=0, state IDLE, flush counter 0, o_overflow=0. All valid/pulse outputs 0.
- Buffer: circular FIFO, p_buf_depth entries. Write when i_inst_valid and state!=FLUSH. Push and pop in the same cycle are both honoured, including when full. A push to a full buffer with no pop is dropped and sets o_overflow until rst.
- Decode of the head entry: op=inst[31:26].
  - J: op=6'h02.
  - JAL: op=6'h03.
  - JR: op=6'h00 and inst[5:0]=6'h08.
  - Everything else is non-jump.
- Jump target: J and JAL use {pc[31:28], inst[25:0], 2'b00}. JR uses i_rs_data.
- States:
  - IDLE: buffer empty. Goes to DISPATCH when the buffer becomes non-empty; the write cycle is not decoded.
  - DISPATCH: head valid.
    - Non-jump head: o_dec_valid=1, o_dec_pc=pc. On i_dec_ready: pop, o_inst_complete=1, pc+=4, go to IDLE if buffer now empty.
    - Jump head: for exactly one cycle, the matching *_valid=1, o_inst_complete=1, pop. For JAL also o_link_valid=1 with o_link_addr=pc+4. pc<=target. Clear whole buffer, load flush counter with p_flush_cycles, go to FLUSH. o_dec_valid is 0 in a jump cycle.
  - FLUSH: every incoming word is discarded (no overflow). Counter decrements each cycle; at 0 go to IDLE.
- Jump pulses are mutually exclusive; one instruction is retired per cycle at most.
- o_dec_* hold stable while o_dec_valid=1 and i_dec_ready=0.
- pc arithmetic wraps modulo 2^p_addr_bits.
- rst has priority over all activity, mid-operation included; the buffer is cleared.

Optional Feature:
INST_DECODE_STATS_EN
- Defined: adds outputs o_stat_retired (32b, +1 per o_inst_complete) and o_stat_jumps (32b, +1 per jump pulse) plus o_stat_flushed (32b, +1 per word discarded in FLUSH). All reset to 0 and wrap.
- Undefined: the outputs and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then push 3 non-jump words (0x20010005, 0x20020006, 0x00221820) with i_dec_ready=1. Required: o_dec_pc 0, 4, 8 on consecutive accepts; 3 o_inst_complete pulses; final pc=12.
- pc=0x10000000, push J 0x08000040. Required: o_j_valid one cycle with o_j_addr=0x10000100; state FLUSH. Words pushed in the next 8 cycles are never dispatched; the first word after that dispatches with pc=0x10000100.
- pc=0x20, push JAL 0x0C000010. Required: o_jal_addr=0x00000040, o_link_addr=0x24, o_link_valid=o_jal_valid=1 for one cycle.
- Push JR 0x03E00008 with i_rs_data=0x00001234. Required: o_rs_idx=31, o_jr_addr=0x1234, one pulse.
- Hold i_dec_ready=0 and push 5 words. Required: o_dec_* stable; o_overflow=1 after the fifth push. Release ready: exactly 4 words are dispatched in order.
- Assert rst while 2 entries are buffered and o_dec_valid=1. Required: next cycle o_dec_valid=0, pc=0, o_overflow=0, and nothing is dispatched afterwards.
